// File: rtl/risc_alu_stage.sv
// Execute stage: computes one decoded op per handshake and routes the result to the
// register, memory or PC channel. Optional multiplier enabled by `RISC_ALU_MUL_EN.
module risc_alu_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      alu_op_code,
  input  logic [XLEN-1:0] alu_input_A,
  input  logic [XLEN-1:0] alu_input_B,
  input  logic            alu_reg_out,
  input  logic [4:0]      alu_reg_addr,
  input  logic            alu_mem_out,
  input  logic [XLEN-1:0] alu_mem_addr,
  input  logic            alu_pc_jump,
  input  logic            alu_inputs_valid,
  output logic            alu_inputs_ready,
  output logic [4:0]      reg_wr_addr,
  output logic [XLEN-1:0] reg_wr_data,
  output logic            reg_wr_valid,
  input  logic            reg_wr_ack,
  output logic [XLEN-1:0] mem_wr_addr,
  output logic [XLEN-1:0] mem_wr_data,
  output logic            mem_wr_valid,
  input  logic            mem_wr_ack,
  output logic [XLEN-1:0] alu_pc_branch_data,
  output logic            alu_pc_branch_data_valid,
  input  logic            alu_pc_branch_data_ack,
  output logic            alu_illegal_op
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSll  = 4'd2;
  localparam logic [3:0] OpSlt  = 4'd3;
  localparam logic [3:0] OpSltu = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpAnd  = 4'd9;
  localparam logic [3:0] OpBeq  = 4'd10;
  localparam logic [3:0] OpBne  = 4'd11;
  localparam logic [3:0] OpBlt  = 4'd12;
  localparam logic [3:0] OpBge  = 4'd13;
  localparam logic [3:0] OpBltu = 4'd14;
  localparam logic [3:0] OpMul  = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
`ifdef RISC_ALU_MUL_EN
    StMul  = 2'd1,
`endif
    StResp = 2'd2
  } state_e;

  typedef enum logic [1:0] {DstReg = 2'd0, DstMem = 2'd1, DstPc = 2'd2} dest_e;

  state_e          state_q, state_d;
  dest_e           dest_q, dest_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      reg_addr_q, reg_addr_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] alu_res, jump_sum;
  logic [4:0]      shamt;
  logic            taken, is_branch, is_mul, illegal, accept, sel_ack;
  state_e          busy_state;

  assign shamt     = alu_input_B[4:0];
  assign is_branch = (alu_op_code >= OpBeq) && (alu_op_code <= OpBltu);
  assign is_mul    = (alu_op_code == OpMul);
  assign accept    = alu_inputs_valid && (state_q == StIdle);
  assign jump_sum  = alu_input_A + alu_input_B;

`ifdef RISC_ALU_MUL_EN
  logic [XLEN-1:0] op_a_q, op_b_q;
  assign illegal    = 1'b0;
  assign busy_state = is_mul ? StMul : StResp;

  // Operands are kept so the product is formed in its own cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (accept) begin
      op_a_q <= alu_input_A;
      op_b_q <= alu_input_B;
    end
  end
`else
  assign illegal    = is_mul;
  assign busy_state = StResp;
`endif

  always_comb begin
    alu_res = '0;
    taken   = 1'b0;
    case (alu_op_code)
      OpAdd:  alu_res = alu_input_A + alu_input_B;
      OpSub:  alu_res = alu_input_A - alu_input_B;
      OpSll:  alu_res = alu_input_A << shamt;
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(alu_input_A) < $signed(alu_input_B)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, alu_input_A < alu_input_B};
      OpXor:  alu_res = alu_input_A ^ alu_input_B;
      OpSrl:  alu_res = alu_input_A >> shamt;
      OpSra:  alu_res = $unsigned($signed(alu_input_A) >>> shamt);
      OpOr:   alu_res = alu_input_A | alu_input_B;
      OpAnd:  alu_res = alu_input_A & alu_input_B;
      OpBeq:  taken = (alu_input_A == alu_input_B);
      OpBne:  taken = (alu_input_A != alu_input_B);
      OpBlt:  taken = $signed(alu_input_A) < $signed(alu_input_B);
      OpBge:  taken = $signed(alu_input_A) >= $signed(alu_input_B);
      OpBltu: taken = (alu_input_A < alu_input_B);
      default: ;
    endcase
  end

  always_comb begin
    sel_ack = 1'b0;
    unique case (dest_q)
      DstReg:  sel_ack = reg_wr_ack;
      DstMem:  sel_ack = mem_wr_ack;
      DstPc:   sel_ack = alu_pc_branch_data_ack;
      default: sel_ack = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    result_d   = result_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    illegal_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (illegal) begin
            illegal_d = 1'b1;
          end else if (alu_pc_jump || is_branch) begin
            // An explicit jump wins over a branch opcode; the target LSB is cleared.
            dest_d   = DstPc;
            result_d = alu_pc_jump ? {jump_sum[XLEN-1:1], 1'b0}
                                   : {{(XLEN-1){1'b0}}, taken};
            state_d  = StResp;
          end else if (alu_reg_out) begin
            if (alu_reg_addr != 5'd0) begin
              dest_d     = DstReg;
              reg_addr_d = alu_reg_addr;
              result_d   = alu_res;
              state_d    = busy_state;
            end
          end else if (alu_mem_out) begin
            dest_d     = DstMem;
            mem_addr_d = alu_mem_addr;
            result_d   = alu_res;
            state_d    = busy_state;
          end
        end
      end
`ifdef RISC_ALU_MUL_EN
      StMul: begin
        result_d = op_a_q * op_b_q;
        state_d  = StResp;
      end
`endif
      StResp: begin
        if (sel_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      dest_q     <= DstReg;
      result_q   <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      result_q   <= result_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_inputs_ready         = (state_q == StIdle);
  assign reg_wr_valid             = (state_q == StResp) && (dest_q == DstReg);
  assign mem_wr_valid             = (state_q == StResp) && (dest_q == DstMem);
  assign alu_pc_branch_data_valid = (state_q == StResp) && (dest_q == DstPc);
  assign reg_wr_addr              = reg_addr_q;
  assign reg_wr_data              = result_q;
  assign mem_wr_addr              = mem_addr_q;
  assign mem_wr_data              = result_q;
  assign alu_pc_branch_data       = result_q;
  assign alu_illegal_op           = illegal_q;

endmodule
